tick_generator: RTL and testbench

Parametrised multi-rate timebase for the clock datapath. Divides the single system clock into a one-cycle `tick` pulse at one of four compile-time rates selected at run time, for example 1 Hz for normal timekeeping and 60 Hz for fast-set. It also provides:
- pause/resume via `enable`
- single-step via `step`
- synchronous `clear`
- glitch-free rate switching
- a 50 % duty `blink` output for display flashing

It feeds the seconds/minutes counters and the display blanking logic.

---
 rtl/tick_generator.sv | 98 +++++++++
 tb/tb_tick_generator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_generator.sv
// Multi-rate timebase: a one-cycle tick at one of four run-time selectable rates,
// plus a 50 % blink square wave, pause, single-step and synchronous clear.
module tick_generator #(
    parameter int CNT_W = 27,
    parameter int DIV_0 = 50_000_000,
    parameter int DIV_1 = 833_333,
    parameter int DIV_2 = 50_000,
    parameter int DIV_3 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       rate_sel,
    input  logic             step,
    input  logic             clear,
    output logic             tick,
    output logic             blink,
    output logic [1:0]       rate_active,
    output logic [CNT_W-1:0] phase
);

    localparam int               DIV_TAB [4] = '{DIV_0, DIV_1, DIV_2, DIV_3};
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    // A period below 2 or one that does not fit the phase counter is a build error.
    for (genvar i = 0; i < 4; i++) begin : g_div_check
        if (DIV_TAB[i] < 2 || (DIV_TAB[i] >> CNT_W) != 0) begin : g_bad_div
            $error("tick_generator: DIV_%0d = %0d outside [2, 2**CNT_W)", i, DIV_TAB[i]);
        end
    end

    function automatic logic [CNT_W-1:0] period_of(input logic [1:0] sel);
        case (sel)
            2'd0:    period_of = CNT_W'(DIV_0);
            2'd1:    period_of = CNT_W'(DIV_1);
            2'd2:    period_of = CNT_W'(DIV_2);
            default: period_of = CNT_W'(DIV_3);
        endcase
    endfunction

    logic             step_q;
    logic             step_rise;
    logic [CNT_W-1:0] cur_len;
    logic [CNT_W-1:0] new_len;
    logic [CNT_W-1:0] phase_next;
    logic [1:0]       rate_next;
    logic             tick_next;
    logic             blink_next;

    // Priority: clear, then rate change, then step (only while paused), then count.
    always_comb begin
        cur_len    = period_of(rate_active);
        new_len    = period_of(rate_sel);
        phase_next = phase;
        rate_next  = rate_active;
        tick_next  = 1'b0;
        if (clear) begin
            phase_next = '0;
            rate_next  = rate_sel;
        end else if (rate_sel != rate_active) begin
            rate_next = rate_sel;
            if (phase > new_len - ONE) begin
                phase_next = new_len - ONE;
            end
        end else if (step_rise && !enable) begin
            phase_next = '0;
            tick_next  = 1'b1;
        end else if (enable) begin
            if (phase == cur_len - ONE) begin
                phase_next = '0;
                tick_next  = 1'b1;
            end else begin
                phase_next = phase + ONE;
            end
        end
    end

    assign blink_next = (phase_next < (period_of(rate_next) >> 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick        <= 1'b0;
            blink       <= 1'b1;
            rate_active <= 2'd0;
            phase       <= '0;
            step_q      <= 1'b0;
            step_rise   <= 1'b0;
        end else begin
            tick        <= tick_next;
            blink       <= blink_next;
            rate_active <= rate_next;
            phase       <= phase_next;
            step_q      <= step;
            step_rise   <= step & ~step_q;
        end
    end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator: a spec-level model fills a scoreboard each
// cycle, and explicit checks pin down the key timing points.
module tb_tick_generator;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [1:0]       rate_sel;
    logic             step;
    logic             clear;
    logic             tick;
    logic             blink;
    logic [1:0]       rate_active;
    logic [CNT_W-1:0] phase;

    typedef struct {
        logic             tick;
        logic             blink;
        logic [1:0]       rate;
        logic [CNT_W-1:0] phase;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    int         m_phase;
    logic [1:0] m_rate;
    logic       m_tick;
    logic       m_blink;
    logic       m_step_q;
    logic       m_rise;

    tick_generator #(
        .CNT_W(CNT_W),
        .DIV_0(10),
        .DIV_1(6),
        .DIV_2(4),
        .DIV_3(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .rate_sel(rate_sel),
        .step(step),
        .clear(clear),
        .tick(tick),
        .blink(blink),
        .rate_active(rate_active),
        .phase(phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int div_of(input logic [1:0] r);
        case (r)
            2'd0:    return 10;
            2'd1:    return 6;
            2'd2:    return 4;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_rate   = 2'd0;
        m_tick   = 1'b0;
        m_blink  = 1'b1;
        m_step_q = 1'b0;
        m_rise   = 1'b0;
    endtask

    // Expected register contents after one clock edge with the given inputs.
    task automatic model_edge(input logic en, input logic [1:0] sel, input logic st, input logic clr);
        exp_t e;
        logic rise_now;
        rise_now = m_rise;
        m_rise   = st & ~m_step_q;
        m_step_q = st;
        m_tick   = 1'b0;
        if (clr) begin
            m_phase = 0;
            m_rate  = sel;
        end else if (sel != m_rate) begin
            m_rate = sel;
            if (m_phase > div_of(sel) - 1) m_phase = div_of(sel) - 1;
        end else if (rise_now && !en) begin
            m_phase = 0;
            m_tick  = 1'b1;
        end else if (en) begin
            if (m_phase == div_of(m_rate) - 1) begin
                m_phase = 0;
                m_tick  = 1'b1;
            end else begin
                m_phase = m_phase + 1;
            end
        end
        m_blink = (m_phase < div_of(m_rate) / 2);
        e.tick  = m_tick;
        e.blink = m_blink;
        e.rate  = m_rate;
        e.phase = CNT_W'(m_phase);
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check("sb_tick",  32'(tick),        32'(e.tick));
            check("sb_blink", 32'(blink),       32'(e.blink));
            check("sb_rate",  32'(rate_active), 32'(e.rate));
            check("sb_phase", 32'(phase),       32'(e.phase));
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] sel, input logic st, input logic clr);
        enable   = en;
        rate_sel = sel;
        step     = st;
        clear    = clr;
        model_edge(en, sel, st, clr);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst      = 1'b0;
        enable   = 1'b1;
        rate_sel = 2'd0;
        step     = 1'b0;
        clear    = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("reset_phase", 32'(phase),       0);
        check("reset_tick",  32'(tick),        0);
        check("reset_rate",  32'(rate_active), 0);
        check("reset_blink", 32'(blink),       1);
        @(posedge clk);
        #2 rst = 1'b0;

        $display("[TB] basic count at rate 0");
        for (int i = 1; i <= 30; i++) begin
            applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
            check("count_tick",  32'(tick),  32'(i % 10 == 0));
            check("count_blink", 32'(blink), 32'((i % 10) < 5));
        end

        $display("[TB] pause and resume");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        check("pause_start_phase", 32'(phase), 4);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
            check("pause_phase", 32'(phase), 4);
            check("pause_tick",  32'(tick),  0);
        end
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
            check("resume_tick", 32'(tick), 32'(i == 6));
        end

        $display("[TB] rate change with clamp");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        check("pre_clamp_phase", 32'(phase), 8);
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
        check("clamp_rate",  32'(rate_active), 2);
        check("clamp_phase", 32'(phase),       3);
        check("clamp_tick",  32'(tick),        0);
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
        check("post_clamp_tick",  32'(tick),  1);
        check("post_clamp_phase", 32'(phase), 0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
            check("fast_tick", 32'(tick), 32'(i % 4 == 0));
        end

        $display("[TB] rate change without clamp");
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
        check("pre_noclamp_phase", 32'(phase), 1);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        check("noclamp_rate",  32'(rate_active), 0);
        check("noclamp_phase", 32'(phase),       1);
        check("noclamp_tick",  32'(tick),        0);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
            check("noclamp_next_tick", 32'(tick), 32'(i == 9));
        end

        $display("[TB] single step");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
            check("step_tick", 32'(tick), 32'(i == 2));
            if (i == 2) check("step_phase", 32'(phase), 0);
        end
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
            check("step_enabled_tick", 32'(tick), 0);
        end
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
            check("step_enabled_spacing", 32'(tick), 32'(i == 5));
        end

        $display("[TB] clear with rate change");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b1);
        check("clear_phase", 32'(phase),       0);
        check("clear_rate",  32'(rate_active), 1);
        check("clear_tick",  32'(tick),        0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        check("pre_reset_phase", 32'(phase), 7);

        $display("[TB] asynchronous reset mid-count");
        #2 rst = 1'b1;
        #1;
        check("async_reset_phase", 32'(phase),       0);
        check("async_reset_tick",  32'(tick),        0);
        check("async_reset_rate",  32'(rate_active), 0);
        check("async_reset_blink", 32'(blink),       1);
        model_reset();
        rate_sel = 2'd3;
        @(posedge clk);
        #2 rst = 1'b0;
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
        check("release_rate", 32'(rate_active), 3);
        check("release_tick", 32'(tick),        0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
            check("release_tick_seq", 32'(tick), 32'(i % 3 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
